// File: rtl/vga_timing_pkg.sv
// Shared VGA 640x480@60 timing constants and the capture-monitor FSM encoding.
package vga_timing_pkg;

  localparam int unsigned VGA_H_ACTIVE = 640;
  localparam int unsigned VGA_H_FP     = 16;
  localparam int unsigned VGA_H_SYNC   = 96;
  localparam int unsigned VGA_H_BP     = 48;
  localparam int unsigned VGA_V_ACTIVE = 480;
  localparam int unsigned VGA_V_FP     = 10;
  localparam int unsigned VGA_V_SYNC   = 2;
  localparam int unsigned VGA_V_BP     = 33;

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_ALIGN  = 2'd1,
    ST_LOCKED = 2'd2
  } vga_state_t;

  // Zero-extend a packed {r,g,b} 12-bit pixel to checksum width.
  function automatic logic [15:0] rgb_word(input logic [11:0] rgb);
    return {4'h0, rgb};
  endfunction

endpackage

// File: rtl/sync_edge_meter.sv
// Falling-edge detector for an active-low sync sample, measuring the
// fall-to-fall period and the width of the most recent low pulse.
module sync_edge_meter #(
  parameter int unsigned CNT_W = 12
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sync_in,
  output logic             fall,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] width,
  output logic             primed
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic             sync_prev;
  logic             rise;
  logic             seen_fall;
  logic [CNT_W-1:0] since_fall;
  logic [CNT_W-1:0] low_run;

  assign fall   = sync_prev & ~sync_in;
  assign rise   = ~sync_prev & sync_in;
  assign period = since_fall;

  // Edge history, saturating period/low-run counters, and width capture on rise.
  // primed means one full pulse has been seen, so period and width are meaningful.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_prev  <= 1'b1;
      since_fall <= '0;
      low_run    <= '0;
      width      <= '0;
      seen_fall  <= 1'b0;
      primed     <= 1'b0;
    end else begin
      sync_prev <= sync_in;
      if (fall)
        since_fall <= ONE;
      else if (since_fall != '1)
        since_fall <= since_fall + ONE;
      if (fall)
        low_run <= ONE;
      else if (!sync_in && low_run != '1)
        low_run <= low_run + ONE;
      if (rise) begin
        width <= low_run;
        if (seen_fall)
          primed <= 1'b1;
      end
      if (fall)
        seen_fall <= 1'b1;
    end
  end

endmodule

// File: rtl/vga_capture_monitor.sv
// Passive VGA stream monitor: locks onto hsync/vsync timing, reconstructs the
// pixel coordinate, checksums each locked frame and flags timing/blanking faults.
module vga_capture_monitor
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE = VGA_H_ACTIVE,
  parameter int unsigned H_FP     = VGA_H_FP,
  parameter int unsigned H_SYNC   = VGA_H_SYNC,
  parameter int unsigned H_BP     = VGA_H_BP,
  parameter int unsigned V_ACTIVE = VGA_V_ACTIVE,
  parameter int unsigned V_FP     = VGA_V_FP,
  parameter int unsigned V_SYNC   = VGA_V_SYNC,
  parameter int unsigned V_BP     = VGA_V_BP
) (
  input  logic        clk25,
  input  logic        reset,
  input  logic        hsync,
  input  logic        vsync,
  input  logic [3:0]  vga_r,
  input  logic [3:0]  vga_g,
  input  logic [3:0]  vga_b,
  output logic [9:0]  cap_x,
  output logic [9:0]  cap_y,
  output logic        cap_valid,
  output logic        locked,
  output logic        frame_done,
  output logic [15:0] frame_checksum,
  output logic [7:0]  err_count,
  output logic        blank_err
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0]  H_LOAD      = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0]  H_LAST      = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_LOAD      = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0]  V_LAST      = 10'(V_TOTAL - 1);
  localparam logic [9:0]  X_END       = 10'(H_ACTIVE);
  localparam logic [9:0]  Y_END       = 10'(V_ACTIVE);
  localparam logic [9:0]  X_LAST      = 10'(H_ACTIVE - 1);
  localparam logic [9:0]  Y_LAST      = 10'(V_ACTIVE - 1);
  localparam logic [9:0]  FRAME_LINES = 10'(V_TOTAL);
  localparam logic [11:0] LINE_PERIOD = 12'(H_TOTAL);
  localparam logic [11:0] SYNC_WIDTH  = 12'(H_SYNC);

  logic        hs_s, vs_s, vs_prev;
  logic [11:0] rgb_s, rgb_d;
  logic        hs_fall, hs_primed, vs_fall;
  logic [11:0] hs_period, hs_width;
  logic        line_good, h_wrap;
  logic [9:0]  h_cnt, v_cnt, line_tally;
  logic        all_good;
  logic        err_event, in_active, last_px;
  logic [15:0] acc;
  vga_state_t  state, state_n;

  // Input sample stage; rgb_d is delayed once more so it lines up with h_cnt/v_cnt,
  // which load on the cycle after the edge is seen in the sampled syncs.
  always_ff @(posedge clk25) begin
    if (reset) begin
      hs_s    <= 1'b1;
      vs_s    <= 1'b1;
      vs_prev <= 1'b1;
      rgb_s   <= '0;
      rgb_d   <= '0;
    end else begin
      hs_s    <= hsync;
      vs_s    <= vsync;
      vs_prev <= vs_s;
      rgb_s   <= {vga_r, vga_g, vga_b};
      rgb_d   <= rgb_s;
    end
  end

  sync_edge_meter #(
    .CNT_W (12)
  ) u_hsync_meter (
    .clk     (clk25),
    .reset   (reset),
    .sync_in (hs_s),
    .fall    (hs_fall),
    .period  (hs_period),
    .width   (hs_width),
    .primed  (hs_primed)
  );

  assign vs_fall   = vs_prev & ~vs_s;
  assign line_good = hs_primed && (hs_period == LINE_PERIOD) && (hs_width == SYNC_WIDTH);
  assign h_wrap    = (h_cnt == H_LAST);

  // Pixel counters; sync edge loads override the free-running wrap.
  always_ff @(posedge clk25) begin
    if (reset) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else begin
      if (hs_fall)
        h_cnt <= H_LOAD;
      else if (h_wrap)
        h_cnt <= '0;
      else
        h_cnt <= h_cnt + 10'd1;
      if (vs_fall)
        v_cnt <= V_LOAD;
      else if (h_wrap && !hs_fall)
        v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 10'd1;
    end
  end

  // Per-vsync-period tracker: hsync falls seen and whether every line was good.
  // A coincident hsync fall counts toward the period that starts on this vsync fall.
  always_ff @(posedge clk25) begin
    if (reset) begin
      line_tally <= '0;
      all_good   <= 1'b0;
    end else if (vs_fall) begin
      line_tally <= hs_fall ? 10'd1 : '0;
      all_good   <= hs_fall ? line_good : 1'b1;
    end else if (hs_fall) begin
      if (line_tally != '1)
        line_tally <= line_tally + 10'd1;
      all_good <= all_good & line_good;
    end
  end

  // Lock state register.
  always_ff @(posedge clk25) begin
    if (reset)
      state <= ST_SEARCH;
    else
      state <= state_n;
  end

  // Lock next-state and error-event decode.
  always_comb begin
    state_n   = state;
    err_event = 1'b0;
    case (state)
      ST_SEARCH: begin
        if (vs_fall)
          state_n = ST_ALIGN;
      end
      ST_ALIGN: begin
        if (vs_fall && line_tally == FRAME_LINES && all_good)
          state_n = ST_LOCKED;
      end
      ST_LOCKED: begin
        if ((hs_fall && !line_good) || (vs_fall && line_tally != FRAME_LINES)) begin
          state_n   = ST_SEARCH;
          err_event = 1'b1;
        end
      end
      default: state_n = ST_SEARCH;
    endcase
  end

  assign locked    = (state == ST_LOCKED);
  assign in_active = (h_cnt < X_END) && (v_cnt < Y_END);
  assign cap_valid = locked && in_active;
  assign cap_x     = locked ? h_cnt : '0;
  assign cap_y     = locked ? v_cnt : '0;
  assign last_px   = cap_valid && (h_cnt == X_LAST) && (v_cnt == Y_LAST);

  // Frame checksum accumulation; losing lock discards the partial frame.
  always_ff @(posedge clk25) begin
    if (reset) begin
      acc            <= '0;
      frame_done     <= 1'b0;
      frame_checksum <= '0;
    end else begin
      frame_done <= 1'b0;
      if (!locked || state_n != ST_LOCKED) begin
        acc <= '0;
      end else if (cap_valid) begin
        if (last_px) begin
          frame_done     <= 1'b1;
          frame_checksum <= acc + rgb_word(rgb_d);
          acc            <= '0;
        end else begin
          acc <= acc + rgb_word(rgb_d);
        end
      end
    end
  end

  // Saturating timing-error count and sticky blanking-colour flag.
  always_ff @(posedge clk25) begin
    if (reset) begin
      err_count <= '0;
      blank_err <= 1'b0;
    end else begin
      if (err_event && err_count != 8'hFF)
        err_count <= err_count + 8'd1;
      if (locked && !in_active && rgb_d != '0)
        blank_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_vga_capture_monitor.sv
// Scoreboard bench for vga_capture_monitor on a reduced timing geometry so
// whole frames stay short; each frame's expected checksum is queued when the
// frame is generated and popped by a monitor on every frame_done pulse.
module tb_vga_capture_monitor;

  localparam int HA = 16, HF = 4, HS = 8, HB = 4;
  localparam int VA = 12, VF = 2, VS = 2, VB = 3;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;

  logic        clk25 = 1'b0;
  logic        reset = 1'b1;
  logic        hsync = 1'b1;
  logic        vsync = 1'b1;
  logic [3:0]  vga_r = '0, vga_g = '0, vga_b = '0;
  logic [9:0]  cap_x, cap_y;
  logic        cap_valid, locked, frame_done, blank_err;
  logic [15:0] frame_checksum;
  logic [7:0]  err_count;

  vga_capture_monitor #(
    .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
    .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB)
  ) dut (
    .clk25          (clk25),
    .reset          (reset),
    .hsync          (hsync),
    .vsync          (vsync),
    .vga_r          (vga_r),
    .vga_g          (vga_g),
    .vga_b          (vga_b),
    .cap_x          (cap_x),
    .cap_y          (cap_y),
    .cap_valid      (cap_valid),
    .locked         (locked),
    .frame_done     (frame_done),
    .frame_checksum (frame_checksum),
    .err_count      (err_count),
    .blank_err      (blank_err)
  );

  always #20 clk25 = ~clk25;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] sb_q[$];
  bit          sweep_en = 1'b0;
  int          sweep_line = 0;
  int          run_len = 0;
  int          run_y = 0;
  bit          seq_ok = 1'b1;
  bit          prev_valid = 1'b0;
  bit          prev_done = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [11:0] pix(input int pat, input int x, input int y);
    logic [31:0] xv;
    logic [31:0] yv;
    xv = x;
    yv = y;
    case (pat)
      1:       return 12'hFFF;
      2:       return {xv[3:0], 8'h00};
      3:       return {xv[3:0], yv[3:0], ~xv[3:0]};
      default: return 12'h000;
    endcase
  endfunction

  // Monitor: pops the scoreboard on frame_done, checks pulse width and line sweeps.
  always @(posedge clk25) begin
    #1;
    if (frame_done) begin
      if (sb_q.size() == 0)
        check("unexpected_frame_done", 32'(frame_done), 32'd0);
      else
        check("frame_checksum", 32'(frame_checksum), 32'(sb_q.pop_front()));
    end
    if (prev_done)
      check("frame_done_width", 32'(frame_done), 32'd0);
    if (sweep_en) begin
      if (cap_valid) begin
        if (!prev_valid) begin
          run_len = 0;
          seq_ok  = 1'b1;
          run_y   = int'(cap_y);
        end
        if (int'(cap_x) != run_len) seq_ok = 1'b0;
        if (int'(cap_y) != run_y)   seq_ok = 1'b0;
        run_len++;
      end else if (prev_valid) begin
        check("sweep_len", run_len, HA);
        check("sweep_seq", 32'(seq_ok), 32'd1);
        check("sweep_y", run_y, sweep_line);
        sweep_line++;
      end
    end
    prev_valid = cap_valid;
    prev_done  = frame_done;
  end

  // One frame of stimulus. lock_chk: 1 = locked must rise one cycle after the
  // sampled vsync fall, 2 = must stay low through that line.
  task automatic send_frame(input int lines, input int pat, input int bad_line,
                            input int blank_line, input int rst_line,
                            input int lock_chk, input bit exp_done);
    logic [15:0] sum;
    logic [11:0] px;
    int          hw;
    sum = '0;
    if (exp_done) begin
      for (int y = 0; y < VA; y++)
        for (int x = 0; x < HA; x++)
          sum = sum + {4'h0, pix(pat, x, y)};
      sb_q.push_back(sum);
    end
    for (int y = 0; y < lines; y++) begin
      for (int x = 0; x < HT; x++) begin
        @(negedge clk25);
        if (y == VA + VF && lock_chk != 0) begin
          if (x == 1) check("lock_before_edge", 32'(locked), 32'd0);
          if (x == 2) check("lock_after_edge", 32'(locked), (lock_chk == 1) ? 32'd1 : 32'd0);
          if (x == HT - 1 && lock_chk == 2) check("lock_hold_low", 32'(locked), 32'd0);
        end
        if (y == rst_line && x == 1) begin
          check("rst_locked", 32'(locked), 32'd0);
          check("rst_cap_xy", {12'd0, cap_x, cap_y}, 32'd0);
          check("rst_cap_valid", 32'(cap_valid), 32'd0);
          check("rst_frame_done", 32'(frame_done), 32'd0);
          check("rst_checksum", 32'(frame_checksum), 32'd0);
          check("rst_err_count", 32'(err_count), 32'd0);
          check("rst_blank_err", 32'(blank_err), 32'd0);
        end
        reset = (y == rst_line && x == 0);
        hw    = (y == bad_line) ? HS - 1 : HS;
        hsync = !(x >= HA + HF && x < HA + HF + hw);
        vsync = !(y >= VA + VF && y < VA + VF + VS);
        px    = (x < HA && y < VA) ? pix(pat, x, y) : 12'h000;
        if (y == blank_line && x == HA + HF + 2) px = 12'h001;
        {vga_r, vga_g, vga_b} = px;
      end
    end
    check("frame_done_seen", sb_q.size(), 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    repeat (4) @(negedge clk25);
    check("reset_locked", 32'(locked), 32'd0);
    check("reset_cap_xy", {12'd0, cap_x, cap_y}, 32'd0);
    check("reset_cap_valid", 32'(cap_valid), 32'd0);
    check("reset_frame_done", 32'(frame_done), 32'd0);
    check("reset_checksum", 32'(frame_checksum), 32'd0);
    check("reset_err_count", 32'(err_count), 32'd0);
    check("reset_blank_err", 32'(blank_err), 32'd0);
    reset = 1'b0;

    send_frame(VT, 1, -1, -1, -1, 0, 1'b0);   // first vsync fall: SEARCH -> ALIGN
    send_frame(VT, 1, -1, -1, -1, 1, 1'b0);   // second vsync fall: lock
    send_frame(VT, 1, -1, -1, -1, 0, 1'b1);   // solid white checksum
    check("locked_steady", 32'(locked), 32'd1);
    check("err_after_lock", 32'(err_count), 32'd0);

    sweep_line = 0;
    sweep_en   = 1'b1;
    send_frame(VT, 2, -1, -1, -1, 0, 1'b1);   // x gradient on red
    sweep_en   = 1'b0;
    send_frame(VT, 3, -1, -1, -1, 0, 1'b1);   // x/y dependent pattern

    send_frame(VT, 1, 5, -1, -1, 0, 1'b0);    // short hsync pulse drops lock
    check("bad_line_unlocked", 32'(locked), 32'd0);
    check("bad_line_err", 32'(err_count), 32'd1);
    send_frame(VT, 1, -1, -1, -1, 1, 1'b0);   // relock on second vsync fall
    send_frame(VT, 1, -1, -1, -1, 0, 1'b1);
    check("err_kept", 32'(err_count), 32'd1);
    check("blank_clear", 32'(blank_err), 32'd0);

    send_frame(VT, 1, -1, 3, -1, 0, 1'b1);    // colour during hsync pulse
    check("blank_set", 32'(blank_err), 32'd1);
    send_frame(VT, 1, -1, -1, -1, 0, 1'b1);
    check("blank_sticky", 32'(blank_err), 32'd1);

    send_frame(VT - 1, 1, -1, -1, 6, 0, 1'b0); // mid-frame reset, short period follows
    check("post_rst_blank", 32'(blank_err), 32'd0);
    check("post_rst_locked", 32'(locked), 32'd0);
    send_frame(VT, 1, -1, -1, -1, 2, 1'b0);   // period of VT-1 lines: stay ALIGN
    send_frame(VT, 1, -1, -1, -1, 1, 1'b0);   // full period: lock
    send_frame(VT, 1, -1, -1, -1, 0, 1'b1);
    check("final_err_count", 32'(err_count), 32'd0);
    check("final_locked", 32'(locked), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_capture_monitor.md
VGA_CAPTURE_MONITOR -- requirements
Module: vga_capture_monitor

Interface
REQ-001 SHALL have parameters H_ACTIVE=640, H_FP=16, H_SYNC=96, H_BP=48, V_ACTIVE=480, V_FP=10, V_SYNC=2, V_BP=33; the sync pulses are active-low.
REQ-002 SHALL have ports `clk25` (in, 1) as the pixel clock and `reset` (in, 1) as the reset; one clock, and reset is synchronous and active-high.
REQ-003 SHALL have inputs `hsync` and `vsync` (in, 1 each), the sync signals under test, and `vga_r`/`vga_g`/`vga_b` (in, 4 each), the pixel colour under test.
REQ-004 SHALL have outputs `cap_x` and `cap_y` (out, 10 each), the reconstructed pixel coordinate, and `cap_valid` (out, 1), meaning locked and inside the active area.
REQ-005 SHALL have output `locked` (out, 1), meaning timing is verified and being tracked.
REQ-006 SHALL have outputs `frame_done` (out, 1), a 1-cycle pulse, and `frame_checksum` (out, 16), the sum for the last complete frame.
REQ-007 SHALL have outputs `err_count` (out, 8), a saturating count of timing errors, and `blank_err` (out, 1), a sticky flag for nonzero RGB during blanking.

Function
REQ-008 SHALL register all inputs once; all behaviour below refers to the registered samples (1-cycle input latency).
REQ-009 SHALL detect an hsync falling edge as sample 1→0, and SHALL load h_cnt=H_ACTIVE+H_FP (656) on that cycle; otherwise h_cnt increments, wrapping 799→0.
REQ-010 SHALL measure, per line, the hsync period (falling edge to falling edge) and the low width; a line is good iff period=800 and width=96.
REQ-011 SHALL increment v_cnt when h_cnt wraps, wrapping 524→0, and SHALL load v_cnt=V_ACTIVE+V_FP (490) on a vsync falling edge.
REQ-012 SHALL implement an FSM with states SEARCH, ALIGN and LOCKED.
REQ-013 SEARCH SHALL move to ALIGN on a vsync falling edge and clear the line-good tracker.
REQ-014 ALIGN SHALL move to LOCKED on the next vsync falling edge iff exactly 525 hsync falling edges occurred since the previous vsync fall and all lines were good; otherwise it SHALL stay in ALIGN and restart tracking.
REQ-015 LOCKED SHALL move to SEARCH on any bad line or on any vsync period ≠525 lines, and SHALL increment `err_count` (saturating at 255) on that event.
REQ-016 `locked` SHALL be 1 exactly while the FSM is in LOCKED.
REQ-017 `cap_x`/`cap_y` SHALL equal h_cnt/v_cnt when locked and 0 otherwise; `cap_valid` = locked & h_cnt<640 & v_cnt<480.
REQ-018 When cap_valid is 1, the block SHALL add the zero-extended {r,g,b} 12-bit value to a 16-bit accumulator, modulo 2^16.
REQ-019 On the cycle after the pixel (639,479) is accumulated, the block SHALL pulse `frame_done`, latch the accumulator into `frame_checksum`, and clear the accumulator.
REQ-020 The accumulator SHALL clear on leaving LOCKED; a frame whose (639,479) pixel is not reached in LOCKED SHALL produce no `frame_done`.
REQ-021 When locked and not cap_valid, any nonzero RGB SHALL set `blank_err`; it SHALL clear only on reset.
REQ-022 If an hsync edge and an h_cnt wrap coincide, the edge load SHALL take priority; if a vsync edge and a v_cnt increment coincide, the vsync load SHALL take priority.

Reset
REQ-023 While `reset`=1, the FSM SHALL be SEARCH, all counters and the accumulator 0, and all outputs 0, including `frame_checksum`, `err_count` and `blank_err`.
REQ-024 A reset asserted mid-frame SHALL abandon the frame with no `frame_done`, and the block SHALL relock only after two vsync falling edges.

Structure
REQ-025 The timing constants and the FSM state encoding SHALL live in the shared package vga_timing_pkg, which vga_controller also uses.
REQ-026 The edge detect plus period/width measurement SHALL be one sub-module, sync_edge_meter, instanced for hsync.

Verification
REQ-027 Standard 640x480 stream, solid white (0xFFF) → locked rises 1 cycle after the 2nd vsync fall; next frame_checksum=0x5000; err_count=0.
REQ-028 Stream with x-gradient r=x[3:0], g=b=0 → frame_checksum equals the bench model sum mod 2^16; cap_x sweeps 0..639 each active line.
REQ-029 One line with hsync width 95 while locked → locked falls, err_count=1, no frame_done for that frame, relock after 2 vsync falls.
REQ-030 Drive rgb=0x001 at h_cnt=700 on one line while locked → blank_err=1 and stays 1 until reset.
REQ-031 Assert reset at v_cnt=200 for 1 cycle → all outputs 0 the next cycle, no frame_done until the frame after relock.
REQ-032 Feed a 524-line frame in ALIGN → stays ALIGN; the next 525-line frame → LOCKED.
